// File: rtl/axis_slice_pkg.sv
// Shared constants for the axis_slice valid/ready register slice.
package axis_slice_pkg;

    localparam int unsigned MODE_FWD  = 0;
    localparam int unsigned MODE_BWD  = 1;
    localparam int unsigned MODE_FULL = 2;

    localparam int unsigned LEVEL_W   = 2;

endpackage

// File: rtl/axis_slice.sv
// Valid/ready register slice: forward, backward (skid) or full two-entry mode,
// selected by MODE, with an occupancy count on level.
module axis_slice
    import axis_slice_pkg::*;
#(
    parameter int unsigned DATA_W = 4,
    parameter int unsigned MODE   = MODE_FULL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DATA_W-1:0]  din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [DATA_W-1:0]  dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [LEVEL_W-1:0] level
);

    if (MODE != MODE_FWD && MODE != MODE_BWD && MODE != MODE_FULL) begin : g_bad_mode
        $error("axis_slice: illegal MODE %0d", MODE);
    end
    if (DATA_W < 1 || DATA_W > 1024) begin : g_bad_width
        $error("axis_slice: illegal DATA_W %0d", DATA_W);
    end

    logic [DATA_W-1:0]  slice_data;
    logic               slice_valid;
    logic               slice_ready;
    logic [LEVEL_W-1:0] slice_level;

    if (MODE == MODE_FWD) begin : g_fwd
        logic [DATA_W-1:0] data_q, data_d;
        logic              valid_q, valid_d;

        always_comb begin
            data_d  = data_q;
            valid_d = valid_q;
            if (din_valid && slice_ready) begin
                data_d  = din;
                valid_d = 1'b1;
            end else if (dout_ready) begin
                valid_d = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= data_d;
                valid_q <= valid_d;
            end
        end

        assign slice_ready = dout_ready || !valid_q;
        assign slice_data  = data_q;
        assign slice_valid = valid_q;
        assign slice_level = LEVEL_W'(valid_q);
    end else if (MODE == MODE_BWD) begin : g_bwd
        logic [DATA_W-1:0] skid_q, skid_d;
        logic              skid_valid_q, skid_valid_d;

        // A beat accepted while downstream stalls parks in the skid register.
        always_comb begin
            skid_d       = skid_q;
            skid_valid_d = skid_valid_q;
            if (skid_valid_q) begin
                if (dout_ready) skid_valid_d = 1'b0;
            end else if (din_valid && !dout_ready) begin
                skid_d       = din;
                skid_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                skid_q       <= '0;
                skid_valid_q <= 1'b0;
            end else begin
                skid_q       <= skid_d;
                skid_valid_q <= skid_valid_d;
            end
        end

        assign slice_ready = !skid_valid_q;
        assign slice_data  = skid_valid_q ? skid_q : din;
        assign slice_valid = skid_valid_q || din_valid;
        assign slice_level = LEVEL_W'(skid_valid_q);
    end else begin : g_full
        logic [DATA_W-1:0]  mem_q [2];
        logic [DATA_W-1:0]  mem_d [2];
        logic               wr_ptr_q, wr_ptr_d;
        logic               rd_ptr_q, rd_ptr_d;
        logic [LEVEL_W-1:0] count_q, count_d;
        logic               push, pop;

        assign push = din_valid && (count_q != 2'd2);
        assign pop  = dout_ready && (count_q != 2'd0);

        always_comb begin
            mem_d    = mem_q;
            wr_ptr_d = wr_ptr_q ^ push;
            rd_ptr_d = rd_ptr_q ^ pop;
            count_d  = count_q;
            if (push) mem_d[wr_ptr_q] = din;
            if (push && !pop)      count_d = count_q + 2'd1;
            else if (pop && !push) count_d = count_q - 2'd1;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mem_q[0] <= '0;
                mem_q[1] <= '0;
                wr_ptr_q <= 1'b0;
                rd_ptr_q <= 1'b0;
                count_q  <= '0;
            end else begin
                mem_q    <= mem_d;
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        assign slice_ready = (count_q != 2'd2);
        assign slice_data  = mem_q[rd_ptr_q];
        assign slice_valid = (count_q != 2'd0);
        assign slice_level = count_q;
    end

    // Reset blanks every output combinationally so nothing leaks while rst is high.
    always_comb begin
        din_ready  = slice_ready && !rst;
        dout       = rst ? '0 : slice_data;
        dout_valid = slice_valid && !rst;
        level      = rst ? '0 : slice_level;
    end

endmodule
